// File: rtl/dram_wbs_if.sv
// Wishbone-style DRAM-side bus between the DMA initiator (master) and the burst responder (slave).
// Signal names keep the _i/_o suffixes as seen from the responder.
interface dram_wbs_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      dram_wbs_cyc_i;
    logic                      dram_wbs_stb_i;
    logic                      dram_wbs_we_i;
    logic [DATA_WIDTH/8-1:0]   dram_wbs_sel_i;
    logic [31:0]               dram_wbs_adr_i;
    logic [DATA_WIDTH-1:0]     dram_wbs_dat_i;
    logic                      dram_wbs_ack_o;
    logic [DATA_WIDTH-1:0]     dram_wbs_dat_o;
    logic                      dram_burst_valid_o;

    modport master (
        output dram_wbs_cyc_i, dram_wbs_stb_i, dram_wbs_we_i, dram_wbs_sel_i,
               dram_wbs_adr_i, dram_wbs_dat_i,
        input  dram_wbs_ack_o, dram_wbs_dat_o, dram_burst_valid_o
    );

    modport slave (
        input  dram_wbs_cyc_i, dram_wbs_stb_i, dram_wbs_we_i, dram_wbs_sel_i,
               dram_wbs_adr_i, dram_wbs_dat_i,
        output dram_wbs_ack_o, dram_wbs_dat_o, dram_burst_valid_o
    );
endinterface

// File: rtl/dram_burst_responder.sv
// On-chip word array behind the DMA engine's DRAM port: byte-enabled single-beat writes,
// fixed-length read bursts after a programmable latency, error ack for out-of-window accesses.
module dram_burst_responder #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          ADDR_WIDTH   = 10,
    parameter int          BURST_LEN    = 4,
    parameter int          READ_LATENCY = 3,
    parameter logic [31:0] BASE_ADDR    = 32'h3800_0000
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    dram_wbs_if.slave  wbs
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int LAT_W  = $clog2(READ_LATENCY + 1);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WR_ACK   = 3'd1;
    localparam logic [2:0] RD_WAIT  = 3'd2;
    localparam logic [2:0] RD_BURST = 3'd3;
    localparam logic [2:0] ERR_ACK  = 3'd4;

    localparam logic [29:0] BASE_W = BASE_ADDR[31:2];

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    logic [2:0]            state_q, state_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  ack_q, ack_d;
    logic                  bv_q, bv_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;

    logic                  req, hit, wr_en;
    logic [29:0]           off_w;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  unused_adr_lsb;

    // Decode in word units; byte lanes of the address carry no information here.
    assign unused_adr_lsb = ^wbs.dram_wbs_adr_i[1:0];
    assign off_w   = wbs.dram_wbs_adr_i[31:2] - BASE_W;
    assign hit     = (wbs.dram_wbs_adr_i[31:2] >= BASE_W) && (off_w[29:ADDR_WIDTH] == '0);
    assign req_idx = off_w[ADDR_WIDTH-1:0];
    assign req     = wbs.dram_wbs_cyc_i & wbs.dram_wbs_stb_i;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        ptr_d   = ptr_q;
        ack_d   = 1'b0;
        bv_d    = 1'b0;
        dat_d   = dat_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!hit) begin
                        state_d = ERR_ACK;
                        ack_d   = 1'b1;
                        dat_d   = '0;
                    end else if (wbs.dram_wbs_we_i) begin
                        wr_en   = 1'b1;
                        state_d = WR_ACK;
                        ack_d   = 1'b1;
                    end else if (READ_LATENCY == 1) begin
                        state_d = RD_BURST;
                        ack_d   = 1'b1;
                        bv_d    = 1'b1;
                        dat_d   = mem[req_idx];
                        ptr_d   = req_idx + ADDR_WIDTH'(1);
                        beat_d  = '0;
                    end else begin
                        state_d = RD_WAIT;
                        lat_d   = LAT_W'(READ_LATENCY - 1);
                        ptr_d   = req_idx;
                    end
                end
            end
            WR_ACK, ERR_ACK: state_d = IDLE;
            RD_WAIT: begin
                if (!wbs.dram_wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (lat_q <= LAT_W'(1)) begin
                    // Outputs are registered, so beat 0 is launched one cycle before it is seen.
                    state_d = RD_BURST;
                    ack_d   = 1'b1;
                    bv_d    = 1'b1;
                    dat_d   = mem[ptr_q];
                    ptr_d   = ptr_q + ADDR_WIDTH'(1);
                    beat_d  = '0;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RD_BURST: begin
                if (!wbs.dram_wbs_cyc_i || beat_q == BEAT_W'(BURST_LEN - 1)) begin
                    state_d = IDLE;
                end else begin
                    ack_d  = 1'b1;
                    bv_d   = 1'b1;
                    dat_d  = mem[ptr_q];
                    ptr_d  = ptr_q + ADDR_WIDTH'(1);
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            ptr_q   <= '0;
            ack_q   <= 1'b0;
            bv_q    <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            bv_q    <= bv_d;
            dat_q   <= dat_d;
        end
    end

    // Array contents survive reset; only the write strobe is gated by it.
    always_ff @(posedge wb_clk_i) begin
        if (wr_en && !wb_rst_i) begin
            for (int b = 0; b < NB; b++) begin
                if (wbs.dram_wbs_sel_i[b]) begin
                    mem[req_idx][8*b +: 8] <= wbs.dram_wbs_dat_i[8*b +: 8];
                end
            end
        end
    end

    assign wbs.dram_wbs_ack_o     = ack_q;
    assign wbs.dram_burst_valid_o = bv_q;
    assign wbs.dram_wbs_dat_o     = dat_q;
endmodule

// File: tb/tb_dram_burst_responder.sv
// Directed bench for dram_burst_responder: writes, bursts, byte enables, wrap, errors, abort, reset.
module tb_dram_burst_responder;
    localparam logic [31:0] BASE = 32'h3800_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    dram_wbs_if #(.DATA_WIDTH(32)) bus ();

    dram_burst_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .BURST_LEN(4), .READ_LATENCY(3), .BASE_ADDR(BASE)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.dram_wbs_cyc_i = 1'b0;
        bus.dram_wbs_stb_i = 1'b0;
        bus.dram_wbs_we_i  = 1'b0;
        bus.dram_wbs_sel_i = 4'h0;
        bus.dram_wbs_adr_i = 32'h0;
        bus.dram_wbs_dat_i = 32'h0;
    endtask

    task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel);
        bus.dram_wbs_cyc_i = 1'b1;
        bus.dram_wbs_stb_i = 1'b1;
        bus.dram_wbs_we_i  = 1'b1;
        bus.dram_wbs_sel_i = sel;
        bus.dram_wbs_adr_i = adr;
        bus.dram_wbs_dat_i = dat;
        tick();
        chk({tag, " ack T+1"}, {31'b0, bus.dram_wbs_ack_o}, 32'd1);
        chk({tag, " bv T+1"}, {31'b0, bus.dram_burst_valid_o}, 32'd0);
        idle_bus();
        tick();
        chk({tag, " ack T+2"}, {31'b0, bus.dram_wbs_ack_o}, 32'd0);
    endtask

    task automatic rd_burst(input string tag, input logic [31:0] adr,
                            input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e = '{e0, e1, e2, e3};
        bus.dram_wbs_cyc_i = 1'b1;
        bus.dram_wbs_stb_i = 1'b1;
        bus.dram_wbs_we_i  = 1'b0;
        bus.dram_wbs_adr_i = adr;
        tick();
        bus.dram_wbs_stb_i = 1'b0;
        chk({tag, " ack T+1"}, {31'b0, bus.dram_wbs_ack_o}, 32'd0);
        tick();
        chk({tag, " ack T+2"}, {31'b0, bus.dram_wbs_ack_o}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("%s beat%0d ack", tag, k), {31'b0, bus.dram_wbs_ack_o}, 32'd1);
            chk($sformatf("%s beat%0d bv", tag, k), {31'b0, bus.dram_burst_valid_o}, 32'd1);
            chk($sformatf("%s beat%0d dat", tag, k), bus.dram_wbs_dat_o, e[k]);
        end
        tick();
        chk({tag, " ack T+7"}, {31'b0, bus.dram_wbs_ack_o}, 32'd0);
        chk({tag, " bv T+7"}, {31'b0, bus.dram_burst_valid_o}, 32'd0);
        chk({tag, " dat hold"}, bus.dram_wbs_dat_o, e[3]);
        idle_bus();
        tick();
    endtask

    initial begin
        idle_bus();
        rst = 1'b1;
        tick();
        tick();
        chk("rst ack", {31'b0, bus.dram_wbs_ack_o}, 32'd0);
        chk("rst bv", {31'b0, bus.dram_burst_valid_o}, 32'd0);
        chk("rst dat", bus.dram_wbs_dat_o, 32'd0);
        rst = 1'b0;
        tick();

        // 1: full-word write then burst read starting at that word
        wr("t1 w5", BASE + 32'h14, 32'h0000_0005, 4'hF);
        wr("t1 w6", BASE + 32'h18, 32'h0000_0006, 4'hF);
        wr("t1 w7", BASE + 32'h1C, 32'h0000_0007, 4'hF);
        wr("t1 w4", BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
        rd_burst("t1 rd", BASE + 32'h10, 32'hDEAD_BEEF, 32'h5, 32'h6, 32'h7);

        // 2: preloaded burst from word 0
        wr("t2 w0", BASE + 32'h0, 32'h11, 4'hF);
        wr("t2 w1", BASE + 32'h4, 32'h22, 4'hF);
        wr("t2 w2", BASE + 32'h8, 32'h33, 4'hF);
        wr("t2 w3", BASE + 32'hC, 32'h44, 4'hF);
        rd_burst("t2 rd", BASE, 32'h11, 32'h22, 32'h33, 32'h44);

        // 3: byte-enable write over a zero word
        wr("t3 w8z", BASE + 32'h20, 32'h0, 4'hF);
        wr("t3 w9", BASE + 32'h24, 32'h9, 4'hF);
        wr("t3 w10", BASE + 32'h28, 32'hA, 4'hF);
        wr("t3 w11", BASE + 32'h2C, 32'hB, 4'hF);
        wr("t3 w8be", BASE + 32'h20, 32'hAABB_CCDD, 4'b0101);
        rd_burst("t3 rd", BASE + 32'h20, 32'h00BB_00DD, 32'h9, 32'hA, 32'hB);

        // 4: burst wraps from the last word to word 0
        wr("t4 w1023", BASE + 32'hFFC, 32'hA, 4'hF);
        wr("t4 w0", BASE + 32'h0, 32'hB, 4'hF);
        wr("t4 w1", BASE + 32'h4, 32'hC, 4'hF);
        wr("t4 w2", BASE + 32'h8, 32'hD, 4'hF);
        rd_burst("t4 rd", BASE + 32'hFFC, 32'hA, 32'hB, 32'hC, 32'hD);

        // 5: out-of-window read gets one error ack, no burst
        bus.dram_wbs_cyc_i = 1'b1;
        bus.dram_wbs_stb_i = 1'b1;
        bus.dram_wbs_we_i  = 1'b0;
        bus.dram_wbs_adr_i = BASE + 32'h1000;
        tick();
        chk("t5 ack T+1", {31'b0, bus.dram_wbs_ack_o}, 32'd1);
        chk("t5 dat T+1", bus.dram_wbs_dat_o, 32'd0);
        chk("t5 bv T+1", {31'b0, bus.dram_burst_valid_o}, 32'd0);
        idle_bus();
        tick();
        chk("t5 ack T+2", {31'b0, bus.dram_wbs_ack_o}, 32'd0);
        chk("t5 bv T+2", {31'b0, bus.dram_burst_valid_o}, 32'd0);
        tick();
        chk("t5 ack T+3", {31'b0, bus.dram_wbs_ack_o}, 32'd0);
        // Below-window write also takes the error path and must not corrupt word 0.
        bus.dram_wbs_cyc_i = 1'b1;
        bus.dram_wbs_stb_i = 1'b1;
        bus.dram_wbs_we_i  = 1'b1;
        bus.dram_wbs_sel_i = 4'hF;
        bus.dram_wbs_adr_i = BASE - 32'h4;
        bus.dram_wbs_dat_i = 32'hFFFF_FFFF;
        tick();
        chk("t5w ack", {31'b0, bus.dram_wbs_ack_o}, 32'd1);
        chk("t5w dat", bus.dram_wbs_dat_o, 32'd0);
        idle_bus();
        tick();

        // 6a: cyc dropped right after beat 1 aborts the burst
        bus.dram_wbs_cyc_i = 1'b1;
        bus.dram_wbs_stb_i = 1'b1;
        bus.dram_wbs_we_i  = 1'b0;
        bus.dram_wbs_adr_i = BASE;
        tick();
        bus.dram_wbs_stb_i = 1'b0;
        tick();
        tick();
        chk("t6 beat0 dat", bus.dram_wbs_dat_o, 32'hB);
        tick();
        chk("t6 beat1 ack", {31'b0, bus.dram_wbs_ack_o}, 32'd1);
        chk("t6 beat1 dat", bus.dram_wbs_dat_o, 32'hC);
        bus.dram_wbs_cyc_i = 1'b0;
        tick();
        chk("t6 abort ack", {31'b0, bus.dram_wbs_ack_o}, 32'd0);
        chk("t6 abort bv", {31'b0, bus.dram_burst_valid_o}, 32'd0);
        wr("t6 wr after abort", BASE + 32'h50, 32'h55, 4'hF);
        tick();
        chk("t6 no late ack", {31'b0, bus.dram_wbs_ack_o}, 32'd0);

        // 6b: reset mid-burst
        bus.dram_wbs_cyc_i = 1'b1;
        bus.dram_wbs_stb_i = 1'b1;
        bus.dram_wbs_we_i  = 1'b0;
        bus.dram_wbs_adr_i = BASE;
        tick();
        bus.dram_wbs_stb_i = 1'b0;
        tick();
        tick();
        tick();
        chk("t6r beat1 dat", bus.dram_wbs_dat_o, 32'hC);
        rst = 1'b1;
        tick();
        chk("t6r ack", {31'b0, bus.dram_wbs_ack_o}, 32'd0);
        chk("t6r bv", {31'b0, bus.dram_burst_valid_o}, 32'd0);
        chk("t6r dat", bus.dram_wbs_dat_o, 32'd0);
        rst = 1'b0;
        bus.dram_wbs_cyc_i = 1'b0;
        tick();
        chk("t6r idle ack", {31'b0, bus.dram_wbs_ack_o}, 32'd0);
        wr("t6r wr after rst", BASE + 32'h54, 32'h66, 4'hF);

        // Array survives reset and the error write left word 0 intact.
        rd_burst("post rd", BASE, 32'hB, 32'hC, 32'hD, 32'h44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
